// File: rtl/fetch_line_unit.sv
// fetch_line_unit: instruction-fetch front end.
//
// Fetches whole cache lines over the Sysbus, splits each response beat into
// INSN_WIDTH-wide lanes and queues them with their PCs for the decoder.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   entry               start PC, taken on the first edge after reset
//   bus_reqcyc/req/tag  burst read request (line-aligned address)
//   bus_reqack          request accepted
//   bus_respcyc/resp    response beat and data (lane 0 = lowest address)
//   bus_resptag         unused
//   bus_respack         beat consumed (combinational)
//   redirect_valid/pc   flush the queue and restart fetch at redirect_pc
//   insn_valid/ready    decoder handshake for the queue head
//   insn_data/pc        head instruction and its PC
//   halted              zero instruction reached and queue drained
module fetch_line_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int INSN_WIDTH     = 32,
  parameter int LINE_BYTES     = 64,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      insn_valid,
  input  logic                      insn_ready,
  output logic [INSN_WIDTH-1:0]     insn_data,
  output logic [63:0]               insn_pc,
  output logic                      halted
);

  localparam int LINE_INSNS = LINE_BYTES * 8 / INSN_WIDTH;
  localparam int BEATS      = LINE_BYTES * 8 / BUS_DATA_WIDTH;
  localparam int LANES      = BUS_DATA_WIDTH / INSN_WIDTH;
  localparam int INSN_BYTES = INSN_WIDTH / 8;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [3:0]    SYSBUS_READ   = 4'h1;
  localparam logic [3:0]    SYSBUS_MEMORY = 4'h1;
  // Occupancy at or below this leaves room for a full line.
  localparam logic [PW-1:0] ROOM_LIMIT = PW'(FIFO_DEPTH - LINE_INSNS);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [63:0]   LINE_MASK  = ~(64'(LINE_BYTES) - 64'd1);

  typedef enum logic [2:0] {S_START, S_ISSUE, S_REQ, S_RESP, S_DRAIN, S_HALT} state_t;

  state_t                    state_reg, state_next;
  logic [63:0]               fetch_pc_reg, fetch_pc_next;
  logic [BW-1:0]             beat_reg, beat_next;
  logic                      halt_seen_reg, halt_seen_next;
  logic                      halted_reg, halted_next;
  logic                      bus_reqcyc_reg, bus_reqcyc_next;
  logic [BUS_DATA_WIDTH-1:0] bus_req_reg, bus_req_next;
  logic [PW-1:0]             wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]             rd_ptr_reg, rd_ptr_next;

  // Several lanes can be written per cycle, so the queue is a register file
  // with an asynchronous head read rather than a block RAM.
  logic [INSN_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [63:0]           pc_mem   [FIFO_DEPTH];

  logic [63:0]           line_addr;
  logic [INSN_WIDTH-1:0] lane_data [LANES];
  logic [63:0]           lane_pc   [LANES];
  logic [PW-1:0]         push_off  [LANES];
  logic [AW-1:0]         wr_idx    [LANES];
  logic [LANES-1:0]      push_en;
  logic [PW-1:0]         push_cnt;
  logic [PW-1:0]         fill;
  logic                  resp_beat;
  logic                  zero_hit;
  logic                  pop;
  logic                  last_beat;
  logic                  unused_ok;

  assign unused_ok   = ^bus_resptag;
  assign line_addr   = fetch_pc_reg & LINE_MASK;
  assign resp_beat   = bus_respcyc && (state_reg == S_RESP);
  assign last_beat   = (beat_reg == LAST_BEAT);
  assign fill        = wr_ptr_reg - rd_ptr_reg;
  assign pop         = insn_valid && insn_ready;

  assign bus_reqcyc  = bus_reqcyc_reg;
  assign bus_req     = bus_req_reg;
  assign bus_reqtag  = BUS_TAG_WIDTH'({SYSBUS_MEMORY, SYSBUS_READ, 8'h00});
  assign bus_respack = bus_respcyc && (state_reg == S_RESP || state_reg == S_DRAIN);
  assign insn_valid  = (wr_ptr_reg != rd_ptr_reg);
  assign insn_data   = data_mem[rd_ptr_reg[AW-1:0]];
  assign insn_pc     = pc_mem[rd_ptr_reg[AW-1:0]];
  assign halted      = halted_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = bus_resp[gi*INSN_WIDTH +: INSN_WIDTH];
      assign lane_pc[gi]   = line_addr
                           + (64'(beat_reg) * 64'(LANES) + 64'(gi)) * 64'(INSN_BYTES);
      assign wr_idx[gi]    = AW'(wr_ptr_reg + push_off[gi]);
    end
  endgenerate

  // Lane selection: lanes before fetch_pc are skipped; the first zero lane
  // stops the line. Accepted lanes are packed into consecutive slots.
  always_comb begin
    push_en  = '0;
    push_cnt = '0;
    zero_hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      push_off[i] = push_cnt;
      if (resp_beat && !halt_seen_reg && !zero_hit && lane_pc[i] >= fetch_pc_reg) begin
        if (lane_data[i] == '0) begin
          zero_hit = 1'b1;
        end else if (!redirect_valid) begin
          push_en[i] = 1'b1;
          push_cnt   = push_cnt + PW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    beat_next       = beat_reg;
    halt_seen_next  = halt_seen_reg;
    bus_reqcyc_next = bus_reqcyc_reg;
    bus_req_next    = bus_req_reg;

    case (state_reg)
      S_START: begin
        fetch_pc_next = entry;
        state_next    = S_ISSUE;
      end
      S_ISSUE: begin
        if (fill <= ROOM_LIMIT) begin
          bus_reqcyc_next = 1'b1;
          bus_req_next    = BUS_DATA_WIDTH'(line_addr);
          state_next      = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_reqack) begin
          bus_reqcyc_next = 1'b0;
          beat_next       = '0;
          state_next      = S_RESP;
        end
      end
      S_RESP: begin
        if (bus_respcyc) begin
          beat_next = beat_reg + BW'(1);
          if (zero_hit) halt_seen_next = 1'b1;
          if (last_beat) begin
            if (halt_seen_reg || zero_hit) begin
              state_next = S_HALT;
            end else begin
              fetch_pc_next = line_addr + 64'(LINE_BYTES);
              state_next    = S_ISSUE;
            end
          end
        end
      end
      S_DRAIN: begin
        // A redirect taken in REQ still owes the bus its acknowledge.
        if (bus_reqcyc_reg) begin
          if (bus_reqack) begin
            bus_reqcyc_next = 1'b0;
            beat_next       = '0;
          end
        end else if (bus_respcyc) begin
          beat_next = beat_reg + BW'(1);
          if (last_beat) state_next = S_ISSUE;
        end
      end
      default: ;  // S_HALT: idle until redirected
    endcase

    if (redirect_valid) begin
      fetch_pc_next  = redirect_pc;
      halt_seen_next = 1'b0;
      case (state_reg)
        S_REQ:   state_next = S_DRAIN;
        // If the final beat lands with the redirect there is nothing to drain.
        S_RESP:  state_next = (bus_respcyc && last_beat) ? S_ISSUE : S_DRAIN;
        S_DRAIN: ;
        default: begin
          // Cancel a request about to be raised for the stale address.
          bus_reqcyc_next = bus_reqcyc_reg;
          bus_req_next    = bus_req_reg;
          state_next      = S_ISSUE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_next = redirect_valid ? '0 : wr_ptr_reg + push_cnt;
    rd_ptr_next = redirect_valid ? '0 : rd_ptr_reg + PW'(pop);
    halted_next = !redirect_valid && (state_reg == S_HALT) && (wr_ptr_next == rd_ptr_next);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_START;
      fetch_pc_reg   <= '0;
      beat_reg       <= '0;
      halt_seen_reg  <= 1'b0;
      halted_reg     <= 1'b0;
      bus_reqcyc_reg <= 1'b0;
      bus_req_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      beat_reg       <= beat_next;
      halt_seen_reg  <= halt_seen_next;
      halted_reg     <= halted_next;
      bus_reqcyc_reg <= bus_reqcyc_next;
      bus_req_reg    <= bus_req_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en[i]) begin
        data_mem[wr_idx[i]] <= lane_data[i];
        pc_mem[wr_idx[i]]   <= lane_pc[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_line_unit.sv
// Bench for fetch_line_unit: a Sysbus responder serves line bursts from a
// synthetic memory, a consumer pops the instruction queue against a
// scoreboard filled by each scenario task.
module tb_fetch_line_unit;

  localparam int BEATS = 8;

  logic        clk;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [63:0] insn_pc;
  logic        halted;

  fetch_line_unit dut (
    .clk(clk), .reset(reset), .entry(entry),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data),
    .insn_pc(insn_pc), .halted(halted)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] req_log[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          pop_budget = 0;
  int          beat_count = 0;
  bit          rsp_enable = 1;
  logic [63:0] zero_addr = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == zero_addr) return 32'h0;
    return 32'hC000_0000 | {4'h0, a[27:0]};
  endfunction

  function automatic logic [63:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic push_exp(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc   = start + 64'(i * 4);
      e.data = mem_word(e.pc);
      sb.push_back(e);
    end
  endtask

  // Sysbus responder: acks requests immediately and streams BEATS beats.
  // Handshakes are judged after inputs settle at the falling edge.
  initial begin : responder
    bit          pend_req, pend_beat, rsp_active;
    logic [63:0] req_seen, rsp_addr, base;
    int          rsp_beat;
    pend_req = 0; pend_beat = 0; rsp_active = 0; rsp_beat = 0;
    req_seen = '0; rsp_addr = '0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    forever begin
      @(negedge clk);
      if (!reset || !rsp_enable) begin
        pend_req = 0; pend_beat = 0; rsp_active = 0;
        if (rsp_enable) begin
          bus_reqack  = 0;
          bus_respcyc = 0;
        end
      end else begin
        if (pend_req) begin
          req_log.push_back(req_seen);
          $display("[%0t] bus request addr=%h", $time, req_seen);
          rsp_active = 1;
          rsp_addr   = req_seen;
          rsp_beat   = 0;
        end
        if (pend_beat) begin
          rsp_beat++;
          beat_count++;
          if (rsp_beat == BEATS) rsp_active = 0;
        end
        bus_reqack  = bus_reqcyc && !rsp_active;
        bus_respcyc = rsp_active;
        base        = rsp_addr + 64'(rsp_beat * 8);
        bus_resp    = {mem_word(base + 64'd4), mem_word(base)};
        #1;
        pend_req  = bus_reqcyc && bus_reqack;
        req_seen  = bus_req;
        pend_beat = bus_respcyc && bus_respack;
      end
    end
  end

  // Consumer: pops the queue head and checks it against the scoreboard.
  initial begin : consumer
    exp_t e;
    insn_ready = 0;
    forever begin
      @(negedge clk);
      insn_ready = (pop_budget > 0) && (sb.size() > 0) && reset;
      #3;
      if (insn_ready && insn_valid && reset && !redirect_valid) begin
        e = sb.pop_front();
        pop_budget--;
        n_vec++;
        if (insn_pc !== e.pc || insn_data !== e.data) begin
          n_err++;
          $display("FAIL insn: got pc=%h data=%h, expected pc=%h data=%h",
                   insn_pc, insn_data, e.pc, e.data);
        end else begin
          $display("[%0t] insn pc=%h data=%h ok", $time, insn_pc, insn_data);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_sb_drain(input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #2;
      if (sb.size() == 0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_reqs(input int n, input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #2;
      if (req_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_beats(input int n, input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #2;
      if (beat_count >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_halted(input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk); #2;
      if (halted === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset(input logic [63:0] e);
    @(negedge clk); #2;
    reset = 0;
    redirect_valid = 0;
    pop_budget = 0;
    entry = e;
    sb.delete();
    req_log.delete();
    beat_count = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    entry = 64'h1000;
    @(negedge clk); #2;
    bus_respcyc = 1;
    #1;
    n_vec++; if (bus_reqcyc !== 1'b0) begin n_err++; $display("FAIL reset_reqcyc: got %b expected 0", bus_reqcyc); end
    n_vec++; if (bus_req !== 64'h0) begin n_err++; $display("FAIL reset_req: got %h expected 0", bus_req); end
    n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL reset_insn_valid: got %b expected 0", insn_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_vec++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL reset_respack: got %b expected 0", bus_respack); end
    n_vec++; if (bus_reqtag !== 13'h1100) begin n_err++; $display("FAIL reqtag: got %h expected 1100", bus_reqtag); end
    bus_respcyc = 0;
    $display("[%0t] test_reset done", $time);
  endtask

  task automatic test_aligned();
    bit ok;
    do_reset(64'h1000);
    push_exp(64'h1000, 16);
    pop_budget = 1000;
    wait_beats(1, 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL aligned_first_beat: got timeout expected beat"); end
    n_vec++; if (insn_valid !== 1'b1) begin n_err++; $display("FAIL aligned_latency: got insn_valid=%b expected 1", insn_valid); end
    wait_sb_drain(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL aligned_drain: got %0d left expected 0", sb.size()); end
    wait_reqs(2, 200, ok);
    n_vec++; if (req_at(0) !== 64'h1000) begin n_err++; $display("FAIL aligned_req0: got %h expected 1000", req_at(0)); end
    n_vec++; if (req_at(1) !== 64'h1040) begin n_err++; $display("FAIL aligned_req1: got %h expected 1040", req_at(1)); end
  endtask

  task automatic test_unaligned();
    bit ok;
    do_reset(64'h1008);
    push_exp(64'h1008, 14);
    pop_budget = 1000;
    wait_sb_drain(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL unaligned_drain: got %0d left expected 0", sb.size()); end
    n_vec++; if (req_at(0) !== 64'h1000) begin n_err++; $display("FAIL unaligned_req0: got %h expected 1000", req_at(0)); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset(64'h3000);
    push_exp(64'h3000, 32);
    repeat (200) @(negedge clk);
    #2;
    n_vec++; if (req_log.size() != 2) begin n_err++; $display("FAIL bp_two_lines: got %0d requests expected 2", req_log.size()); end
    n_vec++; if (beat_count != 16) begin n_err++; $display("FAIL bp_beats: got %0d beats expected 16", beat_count); end
    pop_budget = 15;
    repeat (40) @(negedge clk);
    #2;
    n_vec++; if (sb.size() != 17) begin n_err++; $display("FAIL bp_pop15: got %0d left expected 17", sb.size()); end
    n_vec++; if (req_log.size() != 2) begin n_err++; $display("FAIL bp_no_third: got %0d requests expected 2", req_log.size()); end
    pop_budget = 1;
    wait_reqs(3, 40, ok);
    n_vec++; if (req_at(2) !== 64'h3080) begin n_err++; $display("FAIL bp_third_req: got %h expected 3080", req_at(2)); end
    pop_budget = 16;
    wait_sb_drain(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset(64'h1000);
    wait_beats(3, 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL redir_beats: got timeout expected 3 beats"); end
    n_vec++; if (insn_valid !== 1'b1) begin n_err++; $display("FAIL redir_pre_valid: got %b expected 1", insn_valid); end
    redirect_valid = 1;
    redirect_pc = 64'h2004;
    @(negedge clk);
    redirect_valid = 0;
    #2;
    n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got insn_valid=%b expected 0", insn_valid); end
    push_exp(64'h2004, 15);
    pop_budget = 1000;
    wait_sb_drain(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL redir_drain: got %0d left expected 0", sb.size()); end
    n_vec++; if (req_at(1) !== 64'h2000) begin n_err++; $display("FAIL redir_req: got %h expected 2000", req_at(1)); end
  endtask

  task automatic test_halt();
    bit ok;
    zero_addr = 64'h4014;
    do_reset(64'h4000);
    push_exp(64'h4000, 5);
    pop_budget = 1000;
    wait_sb_drain(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL halt_drain: got %0d left expected 0", sb.size()); end
    wait_halted(50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL halt_flag: got halted=%b expected 1", halted); end
    repeat (30) @(negedge clk);
    #2;
    n_vec++; if (req_log.size() != 1) begin n_err++; $display("FAIL halt_no_req: got %0d requests expected 1", req_log.size()); end
    n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL halt_valid: got %b expected 0", insn_valid); end
    push_exp(64'h5000, 4);
    redirect_valid = 1;
    redirect_pc = 64'h5000;
    @(negedge clk);
    redirect_valid = 0;
    #2;
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_clear: got %b expected 0", halted); end
    wait_sb_drain(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL halt_resume: got %0d left expected 0", sb.size()); end
    n_vec++; if (req_at(1) !== 64'h5000) begin n_err++; $display("FAIL halt_resume_req: got %h expected 5000", req_at(1)); end
    zero_addr = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset(64'h1000);
    wait_beats(2, 100, ok);
    n_vec++; if (insn_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid: got %b expected 1", insn_valid); end
    reset = 0;
    #1;
    n_vec++; if (bus_reqcyc !== 1'b0) begin n_err++; $display("FAIL areset_reqcyc: got %b expected 0", bus_reqcyc); end
    n_vec++; if (insn_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b expected 0", insn_valid); end
    n_vec++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL areset_respack: got %b expected 0", bus_respack); end
    rsp_enable = 0;
    bus_reqack = 0;
    bus_respcyc = 1;
    bus_resp = 64'hDEAD_BEEF_DEAD_BEEF;
    entry = 64'h6000;
    sb.delete();
    req_log.delete();
    beat_count = 0;
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      n_vec++; if (bus_respack !== 1'b0) begin n_err++; $display("FAIL areset_stray_beat%0d: got respack=%b expected 0", c, bus_respack); end
    end
    n_vec++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h6000) begin n_err++; $display("FAIL areset_new_req: got cyc=%b addr=%h expected 1/6000", bus_reqcyc, bus_req); end
    bus_respcyc = 0;
    rsp_enable = 1;
    push_exp(64'h6000, 4);
    pop_budget = 1000;
    wait_sb_drain(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL areset_drain: got %0d left expected 0", sb.size()); end
    n_vec++; if (req_at(0) !== 64'h6000) begin n_err++; $display("FAIL areset_req0: got %h expected 6000", req_at(0)); end
  endtask

  initial begin
    reset = 0;
    entry = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_line_unit.md
Name: fetch_line_unit

Overview:
- Parametrised instruction-fetch front end.
- Issues line-sized burst reads on the Sysbus, unpacks each bus beat into INSN_WIDTH instruction lanes, and buffers them with their PCs in an internal FIFO for the decoder (valid/ready).
- Adds what single-shot fetch lacks: configurable widths and line size, decoder backpressure, PC redirect with in-flight burst discard, and an orderly zero-instruction halt.

Parameters:
- BUS_DATA_WIDTH, 64, bus beat width; a multiple of INSN_WIDTH.
- BUS_TAG_WIDTH, 13, Sysbus tag width.
- INSN_WIDTH, 32, instruction width; also the PC step in bits, so the PC step is INSN_WIDTH/8 bytes.
- LINE_BYTES, 64, bytes per burst; a power of 2, and LINE_BYTES*8 is a multiple of BUS_DATA_WIDTH.
- FIFO_DEPTH, 32, instruction entries; a power of 2, and at least LINE_INSNS = LINE_BYTES*8/INSN_WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- entry  in  64  start PC, sampled on the first clk edge after reset deasserts.
- bus_reqcyc  out  1  request valid.
- bus_req  out  BUS_DATA_WIDTH  line-aligned request address.
- bus_reqtag  out  BUS_TAG_WIDTH  tag = SYSBUS_READ<<8 | SYSBUS_MEMORY<<12.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response data; lane 0 is bits [INSN_WIDTH-1:0] and is the lowest address.
- bus_resptag  in  BUS_TAG_WIDTH  ignored.
- bus_respack  out  1  beat consumed.
- redirect_valid  in  1  flush the FIFO and restart at redirect_pc.
- redirect_pc  in  64  new PC, INSN_WIDTH/8-aligned.
- insn_valid  out  1  FIFO head valid.
- insn_ready  in  1  decoder accepts the head.
- insn_data  out  INSN_WIDTH  instruction at the FIFO head.
- insn_pc  out  64  PC of insn_data.
- halted  out  1  zero instruction seen and FIFO drained.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - Registered outputs: bus_reqcyc=0, bus_req=0, insn_valid=0, halted=0.
  - FIFO empty, state START.
  - bus_respack is combinational: bus_respcyc && state is RESP or DRAIN. It is 0 in reset.
  - bus_reqtag is constant.
- Definitions:
  - BEATS = LINE_BYTES*8/BUS_DATA_WIDTH.
  - LANES = BUS_DATA_WIDTH/INSN_WIDTH.
  - line address = fetch_pc with the low log2(LINE_BYTES) bits cleared.
- START: fetch_pc <= entry; go to ISSUE.
- ISSUE: when FIFO free entries >= LINE_INSNS, assert bus_reqcyc with bus_req = line address, then go to REQ. If there is not enough room, wait; space is credit-checked, so a line is never dropped for lack of space.
- REQ:
  - bus_reqcyc and bus_req are held stable until bus_reqack=1.
  - On that edge, bus_reqcyc <= 0, the beat counter is cleared, and the state goes to RESP.
- RESP, on each bus_respcyc beat:
  - Each lane is pushed in order 0..LANES-1, with PC = line address + (beat*LANES + lane)*INSN_WIDTH/8.
  - Skip lanes whose PC < fetch_pc (unaligned entry or redirect).
  - On the first lane equal to 0, stop pushing and set halt_seen. The zero lane and every later lane/beat of the line are consumed but dropped.
  - After beat BEATS-1: if halt_seen, go to HALT. Otherwise fetch_pc <= line address + LINE_BYTES and go to ISSUE.
- Redirect:
  - Any state: the FIFO flushes the same cycle, fetch_pc <= redirect_pc, halt_seen and halted clear.
  - In START, ISSUE or HALT: go to ISSUE.
  - In REQ or RESP: go to DRAIN. A redirect arriving in REQ still waits for bus_reqack.
  - DRAIN acks and discards the remaining beats of the outstanding burst, then goes to ISSUE.
  - A redirect in DRAIN only updates fetch_pc.
- Same-cycle events:
  - Redirect beats push: that beat is discarded.
  - Push and pop in the same cycle are both allowed.
  - Pop while redirecting: the flush wins.
- FIFO: insn_valid = not empty; a pop occurs on insn_valid && insn_ready. Read and write pointers wrap modulo FIFO_DEPTH, with an extra bit distinguishing full from empty.
- HALT: no further requests. halted = 1 once the FIFO is empty.
- Latency: with an empty FIFO, the first instruction of a beat is visible on insn_valid the cycle after its bus_respcyc edge.
- Reset mid-burst: all state clears immediately. Beats arriving before the next REQ get bus_respack=0.

Test Plan:
- Aligned stream: entry=0x1000 with BEATS=8, LANES=2 and nonzero words; insn_ready=1 → REQ address 0x1000; 16 instructions with PCs 0x1000..0x103C; next request 0x1040.
- Unaligned entry: entry=0x1008 → request 0x1000; the first insn_pc is 0x1008; 14 instructions pushed from the line.
- Backpressure: insn_ready=0, FIFO_DEPTH=32 → exactly 2 lines fetched and FIFO full; no third bus_reqcyc until 16 pops free space.
- Redirect mid-burst: redirect_pc=0x2004 during beat 3 → FIFO empties; beats 3..7 are acked and dropped; the next request is 0x2000; the first insn_pc is 0x2004.
- Zero halt: beat 2 lane 1 = 0 → 5 instructions delivered; no further requests; halted=1 after the last pop. A subsequent redirect clears halted and resumes fetch.
- Async reset: reset low during RESP → bus_reqcyc=0 and insn_valid=0 with no clock edge. After release, fetch restarts at the new entry.
